// File: rtl/alu_pkg.sv
// Shared ALU types: select codes, sequencer states, default datapath width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_alu_state_t;

  // True for the three codes that take the iterative shift path.
  function automatic logic is_shift_op(input alu_sel_t sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One partial shift: moves an XLEN value by k positions (k <= SHIFT_STEP).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int SHIFT_STEP = 1,
  parameter int KW         = $clog2(SHIFT_STEP + 1)
) (
  input  logic [XLEN-1:0] i_val,
  input  logic [KW-1:0]   i_k,
  input  logic            i_left,
  input  logic            i_arith,
  output logic [XLEN-1:0] o_val
);

  // Arithmetic right shift refills with the current MSB, which is the
  // original sign bit because every step preserves it.
  always_comb begin
    if (i_left) begin
      o_val = i_val << i_k;
    end else if (i_arith) begin
      o_val = $unsigned($signed(i_val) >>> i_k);
    end else begin
      o_val = i_val >> i_k;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith, iterative shifts of SHIFT_STEP bits/cycle.
// Latency: 1 cycle, or 1 + ceil(shamt/SHIFT_STEP) for shifts with nonzero shamt.
// Backpressure: result held in DONE until rsp_ready_i; req_ready_o follows rsp_ready_i there.
module seq_alu
  import alu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      alu_sel_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  localparam int         KW     = $clog2(SHIFT_STEP + 1);
  localparam logic [4:0] STEP_5 = 5'(SHIFT_STEP);

  seq_alu_state_t r_state, w_next_state;

  logic [XLEN-1:0] r_result, r_val;
  logic            r_zero, r_left, r_arith;
  logic [4:0]      r_rem;

  alu_sel_t        w_sel;
  logic [4:0]      w_shamt, w_kfull;
  logic [KW-1:0]   w_k;
  logic            w_accept, w_start_shift, w_last;
  logic [XLEN-1:0] w_comb, w_shifted;

  assign w_sel         = alu_sel_t'(alu_sel_i);
  assign w_shamt       = op_b_i[4:0];
  assign w_accept      = req_valid_i & req_ready_o;
  assign w_start_shift = is_shift_op(w_sel) && (w_shamt != 5'd0);
  assign w_kfull       = (r_rem > STEP_5) ? STEP_5 : r_rem;
  assign w_k           = w_kfull[KW-1:0];
  assign w_last        = (r_rem == w_kfull);
  assign result_o      = r_result;
  assign zero_o        = r_zero;

  alu_shift_step #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP),
    .KW         (KW)
  ) u_shift_step (
    .i_val   (r_val),
    .i_k     (w_k),
    .i_left  (r_left),
    .i_arith (r_arith),
    .o_val   (w_shifted)
  );

  // Single-cycle result; a shift only lands here when shamt is zero, so it passes op_a.
  always_comb begin
    w_comb = '0;
    case (w_sel)
      ALU_ADD:  w_comb = op_a_i + op_b_i;
      ALU_SUB:  w_comb = op_a_i - op_b_i;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  w_comb = op_a_i;
      ALU_SLT:  w_comb = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      ALU_SLTU: w_comb = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
      ALU_XOR:  w_comb = op_a_i ^ op_b_i;
      ALU_OR:   w_comb = op_a_i | op_b_i;
      ALU_AND:  w_comb = op_a_i & op_b_i;
      default:  w_comb = '0;
    endcase
  end

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: IDLE and DONE both take new requests, DONE drains to IDLE otherwise.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_next_state = w_start_shift ? SHIFT : DONE;
        end else if (r_state == DONE && rsp_ready_i) begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; DONE passes consumer readiness straight through.
  always_comb begin
    rsp_valid_o = 1'b0;
    req_ready_o = 1'b0;
    case (r_state)
      IDLE:    req_ready_o = 1'b1;
      SHIFT:   req_ready_o = 1'b0;
      DONE: begin
        rsp_valid_o = 1'b1;
        req_ready_o = rsp_ready_i;
      end
      default: req_ready_o = 1'b0;
    endcase
  end

  // Datapath: capture operands at accept, iterate shifts, register result and zero flag together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_val    <= '0;
      r_rem    <= '0;
      r_left   <= 1'b0;
      r_arith  <= 1'b0;
    end else if (w_accept) begin
      if (w_start_shift) begin
        r_val   <= op_a_i;
        r_rem   <= w_shamt;
        r_left  <= (w_sel == ALU_SLL);
        r_arith <= (w_sel == ALU_SRA);
      end else begin
        r_result <= w_comb;
        r_zero   <= (w_comb == '0);
      end
    end else if (r_state == SHIFT) begin
      r_val <= w_shifted;
      r_rem <= r_rem - w_kfull;
      if (w_last) begin
        r_result <= w_shifted;
        r_zero   <= (w_shifted == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed table, back-to-back, backpressure, reset mid-shift, random ops.
// Latency: checks response cycle count against the shift-step formula.
// Backpressure: exercises held responses with rsp_ready_i low.
module tb_seq_alu;

  localparam int XLEN = 32;
  localparam int STEP = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] op_a, op_b;
  logic            rsp_valid, rsp_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .alu_sel_i   (alu_sel),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .result_o    (result),
    .zero_o      (zero)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: the ISA meaning of each select code.
  function automatic logic [31:0] model(input logic [3:0] sel, input logic [31:0] a,
                                        input logic [31:0] b);
    int unsigned sh;
    sh = int'(b[4:0]);
    case (sel)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return $unsigned($signed(a) >>> sh);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] sel, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if ((sel == 4'd2 || sel == 4'd6 || sel == 4'd7) && sh != 0) return 1 + (sh + STEP - 1) / STEP;
    return 1;
  endfunction

  // Issue one request from IDLE, wait for the response, hold it `hold` cycles, then drain.
  task automatic run_op(input string name, input logic [3:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int hold);
    int n;
    @(negedge clk);
    check({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    alu_sel = sel; op_a = a; op_b = b; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; alu_sel = 4'($urandom);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_result"}, result, exp);
    check({name, "_zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    repeat (hold) begin
      @(negedge clk);
      check({name, "_held"}, result, exp);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({name, "_drained"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic seen;
    logic [3:0]  rs;
    logic [31:0] ra, rb;

    tbl[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1};
    tbl[1]  = '{4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1};
    tbl[2]  = '{4'd2,  32'h0000_0001, 32'h0000_0005, 32'h0000_0020, 6};
    tbl[3]  = '{4'd7,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 32};
    tbl[4]  = '{4'd6,  32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1};
    tbl[5]  = '{4'd3,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1};
    tbl[6]  = '{4'd4,  32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1};
    tbl[7]  = '{4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1};
    tbl[8]  = '{4'd5,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1};
    tbl[9]  = '{4'd8,  32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1};
    tbl[10] = '{4'd9,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1};
    tbl[11] = '{4'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 5};
    tbl[12] = '{4'd7,  32'hF000_0000, 32'h0000_0024, 32'hFF00_0000, 5};
    tbl[13] = '{4'd2,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32};

    // Reset held two cycles with a request pending.
    rst_n = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    alu_sel = 4'd0; op_a = 32'd1; op_b = 32'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    req_valid = 1'b0; rsp_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_accept", {31'd0, rsp_valid}, 32'd0);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 0);
    end

    // Back-to-back add then sub with the consumer always ready.
    @(negedge clk);
    alu_sel = 4'd0; op_a = 32'h7FFF_FFFF; op_b = 32'd1; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    alu_sel = 4'd1; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk);
    check("b2b_add_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_add_result", result, 32'h8000_0000);
    check("b2b_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_sub_valid", {31'd0, rsp_valid}, 32'd1);
    check("b2b_sub_result", result, 32'd0);
    check("b2b_sub_zero", {31'd0, zero}, 32'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("b2b_idle", {31'd0, rsp_valid}, 32'd0);

    // Backpressure: xor response held ten cycles, no new request accepted.
    @(negedge clk);
    alu_sel = 4'd5; op_a = 32'h0000_F0F0; op_b = 32'h0000_0FF0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    alu_sel = 4'd0; op_a = 32'd7; op_b = 32'd9;
    repeat (10) begin
      @(negedge clk);
      check("bp_result", result, 32'h0000_FF00);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_release_idle", {31'd0, rsp_valid}, 32'd0);
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);

    // Reset in the middle of a long shift.
    @(negedge clk);
    alu_sel = 4'd2; op_a = 32'd1; op_b = 32'd20; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("midrst_no_rsp", {31'd0, seen}, 32'd0);
    run_op("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5, 1, 0);

    // Random operations against the reference model, with random consumer stalls.
    for (int i = 0; i < 150; i++) begin
      rs = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000 | ra;
      run_op($sformatf("rnd%0d", i), rs, ra, rb, model(rs, ra, rb), model_lat(rs, rb),
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
